// File: rtl/piso_pkg.sv
// Shared constants for the PISO serializer: FSM state encoding and bit-order selectors.
package piso_pkg;

    // FSM state encoding (single bit, legacy-compatible)
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    // Bit-order selectors for the MSB_FIRST parameter
    localparam logic ORDER_LSB = 1'b0;
    localparam logic ORDER_MSB = 1'b1;

endpackage : piso_pkg

// File: rtl/piso_bit_cnt.sv
// Modulo-WIDTH bit counter with synchronous clear, enable and terminal-count flag.
// Counts 0..WIDTH-1 and wraps to 0 on an enabled edge at terminal count, so it
// never holds a value beyond WIDTH-1.
module piso_bit_cnt #(
    parameter int WIDTH = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       clr,
    input  logic                                       en,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] cnt,
    output logic                                       tc
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] cnt_r;

    // Counter register: reset and clear take priority, then wrap or increment on enable
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (clr) begin
            cnt_r <= CNT_ZERO;
        end else if (en) begin
            if (cnt_r == TC_VAL) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Expose count and terminal-count flag
    always_comb begin
        cnt = cnt_r;
        tc  = (cnt_r == TC_VAL);
    end

endmodule : piso_bit_cnt

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load, frame bit counter,
// selectable bit order and busy/last/done status. o_ready deliberately depends
// combinationally on in_en so a new word can be taken on the final-bit edge,
// giving a gap-free stream between back-to-back frames.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic [WIDTH-1:0] in_l,
    input  logic             in_valid,
    output logic             o_ready,
    input  logic             in_en,
    input  logic             in_si,
    output logic             o_q,
    output logic             o_busy,
    output logic             o_last,
    output logic             o_done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             state_r;
    logic [WIDTH-1:0] shift_r;
    logic             done_r;

    logic [CNT_W-1:0] cnt_s;
    logic             tc_s;
    logic             last_s;
    logic             end_s;
    logic             load_s;
    logic             adv_s;
    logic [WIDTH-1:0] shift_nxt_s;
    logic             out_bit_s;

    // Frame bit counter; cleared on every accepted load, advanced on enabled shift edges
    piso_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk (in_clk),
        .rst (in_rst),
        .clr (load_s),
        .en  (adv_s),
        .cnt (cnt_s),
        .tc  (tc_s)
    );

    // Handshake, frame-end and next-shift-value decode
    always_comb begin
        last_s  = (state_r == ST_SHIFT) && tc_s;
        end_s   = last_s && in_en;
        o_ready = !in_rst && ((state_r == ST_IDLE) || end_s);
        load_s  = in_valid && o_ready;
        adv_s   = (state_r == ST_SHIFT) && in_en;
        if (MSB_FIRST == ORDER_MSB) begin
            shift_nxt_s = {shift_r[WIDTH-2:0], in_si};
            out_bit_s   = shift_r[WIDTH-1];
        end else begin
            shift_nxt_s = {in_si, shift_r[WIDTH-1:1]};
            out_bit_s   = shift_r[0];
        end
    end

    // FSM: load moves to SHIFT, an unreloaded frame end returns to IDLE
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        state_r <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (load_s) begin
                        state_r <= ST_SHIFT;
                    end else if (end_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Shift register: load wins over shift; holds while in_en is low
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            shift_r <= {WIDTH{1'b0}};
        end else if (load_s) begin
            shift_r <= in_l;
        end else if (adv_s) begin
            shift_r <= shift_nxt_s;
        end else begin
            shift_r <= shift_r;
        end
    end

    // Done pulse: high for the cycle after the final bit's enabled edge
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= end_s;
        end
    end

    // Output mux: idle level outside a frame, otherwise the output-end register bit
    always_comb begin
        if (state_r == ST_SHIFT) begin
            o_q = out_bit_s;
        end else begin
            o_q = IDLE_LEVEL;
        end
        o_busy = (state_r == ST_SHIFT);
        o_last = last_s;
        o_done = done_r;
    end

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer: an 8-bit MSB-first instance
// and a 4-bit LSB-first instance share one clock.
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] l8;
    logic       valid8, en8, si8;
    logic       ready8, q8, busy8, last8, done8;
    logic [3:0] l4;
    logic       valid4, en4, si4;
    logic       ready4, q4, busy4, last4, done4;

    int checks;
    int failures;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut8 (
        .in_clk(clk), .in_rst(rst), .in_l(l8), .in_valid(valid8), .o_ready(ready8),
        .in_en(en8), .in_si(si8), .o_q(q8), .o_busy(busy8), .o_last(last8), .o_done(done8)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut4 (
        .in_clk(clk), .in_rst(rst), .in_l(l4), .in_valid(valid4), .o_ready(ready4),
        .in_en(en4), .in_si(si4), .o_q(q4), .o_busy(busy4), .o_last(last4), .o_done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid8 = 1'b0; en8 = 1'b0; si8 = 1'b0; l8 = 8'h00;
        valid4 = 1'b0; en4 = 1'b0; si4 = 1'b0; l4 = 4'h0;
        step(); step();
        checks++;
        if (ready8 !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready8); end
        rst = 1'b0;
        #1;
        checks++;
        if ({q8, busy8, last8, done8, ready8} !== 5'b00001) begin
            failures++; $display("FAIL reset_state got=%b exp=00001", {q8, busy8, last8, done8, ready8});
        end
    endtask

    task automatic test_msb_frame();
        logic [7:0] exp;
        exp = 8'hB4;
        l8 = 8'hB4; valid8 = 1'b1; en8 = 1'b1; si8 = 1'b0;
        step();
        valid8 = 1'b0; l8 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({q8, busy8, last8} !== {exp[7-i], 1'b1, (i == 7)}) begin
                failures++; $display("FAIL msb_bit%0d got q/busy/last=%b%b%b exp=%b1%b", i, q8, busy8, last8, exp[7-i], (i == 7));
            end
            step();
        end
        checks++;
        if ({done8, q8, busy8, ready8} !== 4'b1001) begin
            failures++; $display("FAIL msb_done got done/q/busy/ready=%b exp=1001", {done8, q8, busy8, ready8});
        end
        step();
        checks++;
        if (done8 !== 1'b0) begin failures++; $display("FAIL msb_done_pulse got=%b exp=0", done8); end
    endtask

    task automatic test_lsb_frame();
        logic [3:0] exp;
        exp = 4'b1101;
        l4 = 4'b1101; valid4 = 1'b1; en4 = 1'b1; si4 = 1'b1;
        step();
        valid4 = 1'b0; l4 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({q4, busy4, last4} !== {exp[i], 1'b1, (i == 3)}) begin
                failures++; $display("FAIL lsb_bit%0d got q/busy/last=%b%b%b exp=%b1%b", i, q4, busy4, last4, exp[i], (i == 3));
            end
            step();
        end
        checks++;
        if ({done4, q4, busy4} !== 3'b100) begin
            failures++; $display("FAIL lsb_end got done/q/busy=%b exp=100", {done4, q4, busy4});
        end
        en4 = 1'b0; si4 = 1'b0;
    endtask

    task automatic test_stall();
        logic [7:0] exp;
        int busy_cycles;
        int bit_idx;
        exp = 8'hB4; busy_cycles = 0; bit_idx = 0;
        l8 = 8'hB4; valid8 = 1'b1; en8 = 1'b1;
        step();
        valid8 = 1'b0;
        for (int c = 0; c < 11; c++) begin
            en8 = !(c >= 3 && c < 6);
            #1;
            if (busy8) busy_cycles++;
            checks++;
            if (q8 !== exp[7-bit_idx]) begin
                failures++; $display("FAIL stall_c%0d got q=%b exp=%b", c, q8, exp[7-bit_idx]);
            end
            if (en8) bit_idx++;
            step();
        end
        checks++;
        if (busy_cycles != 11 || busy8 !== 1'b0 || done8 !== 1'b1) begin
            failures++; $display("FAIL stall_len got busy_cycles=%0d busy=%b done=%b exp=11 0 1", busy_cycles, busy8, done8);
        end
        en8 = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        int dones;
        exp = 16'hB45A; dones = 0;
        l8 = 8'hB4; valid8 = 1'b1; en8 = 1'b1;
        step();
        valid8 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 7) begin valid8 = 1'b1; l8 = 8'h5A; end
            else begin valid8 = 1'b0; end
            #1;
            if (done8) dones++;
            checks++;
            if ({q8, busy8, last8, ready8} !== {exp[15-i], 1'b1, (i == 7 || i == 15), (i == 7 || i == 15)}) begin
                failures++; $display("FAIL b2b_bit%0d got q/busy/last/ready=%b%b%b%b exp q=%b", i, q8, busy8, last8, ready8, exp[15-i]);
            end
            step();
        end
        if (done8) dones++;
        checks++;
        if (dones != 2 || busy8 !== 1'b0) begin
            failures++; $display("FAIL b2b_done got dones=%0d busy=%b exp=2 0", dones, busy8);
        end
    endtask

    task automatic test_ignore_load();
        logic [7:0] exp;
        exp = 8'hB4;
        l8 = 8'hB4; valid8 = 1'b1; en8 = 1'b1;
        step();
        valid8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin valid8 = 1'b1; l8 = 8'hFF; end
            else begin valid8 = 1'b0; end
            #1;
            checks++;
            if (q8 !== exp[7-i] || (i == 3 && ready8 !== 1'b0)) begin
                failures++; $display("FAIL ignore_bit%0d got q=%b ready=%b exp q=%b", i, q8, ready8, exp[7-i]);
            end
            step();
        end
        checks++;
        if ({busy8, done8} !== 2'b01) begin
            failures++; $display("FAIL ignore_end got busy/done=%b exp=01", {busy8, done8});
        end
        step();
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp;
        l8 = 8'hB4; valid8 = 1'b1; en8 = 1'b1;
        step();
        valid8 = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        #1;
        checks++;
        if (ready8 !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ready8); end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({q8, busy8, last8, done8} !== 4'b0000) begin
            failures++; $display("FAIL rst_abort got q/busy/last/done=%b exp=0000", {q8, busy8, last8, done8});
        end
        step();
        checks++;
        if (done8 !== 1'b0) begin failures++; $display("FAIL rst_no_done got=%b exp=0", done8); end
        exp = 8'h5A;
        l8 = 8'h5A; valid8 = 1'b1;
        step();
        valid8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({q8, last8} !== {exp[7-i], (i == 7)}) begin
                failures++; $display("FAIL rst_reload_bit%0d got q/last=%b%b exp=%b%b", i, q8, last8, exp[7-i], (i == 7));
            end
            step();
        end
        checks++;
        if ({done8, busy8} !== 2'b10) begin
            failures++; $display("FAIL rst_reload_end got done/busy=%b exp=10", {done8, busy8});
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_msb_frame();
        test_lsb_frame();
        test_stall();
        step();
        test_back_to_back();
        step();
        test_ignore_load();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_piso_serializer
